// File: rtl/elastic_operator_if.sv
// elastic_operator_if: req/ack pulse bundle between an elastic operator and its
// upstream producers (req_l/ack_l/din) and downstream consumers (req_r/ack_r/dout).
interface elastic_operator_if #(
    parameter int data_width  = 32,
    parameter int input_size  = 2,
    parameter int output_size = 1
);
    logic [input_size-1:0]            req_l;
    logic [input_size-1:0]            ack_l;
    logic [data_width*input_size-1:0] din;
    logic [output_size-1:0]           req_r;
    logic [output_size-1:0]           ack_r;
    logic [data_width-1:0]            dout;
    logic                             overflow;
    logic [31:0]                      fire_count;
    modport master (input req_l, ack_r, dout, overflow, fire_count, output ack_l, din, req_r);
    modport slave (output req_l, ack_r, dout, overflow, fire_count, input ack_l, din, req_r);
endinterface

// File: rtl/elastic_operator.sv
// elastic_operator: N-input, M-output arithmetic dataflow node with a FIFO per input
// and independent (eager-fork) acknowledgement of each output; rst is active-low.
module elastic_operator #(
    parameter int                    data_width  = 32,
    parameter int                    input_size  = 2,
    parameter int                    output_size = 1,
    parameter int                    fifo_depth  = 4,
    parameter string                 op          = "add",
    parameter logic [data_width-1:0] immediate   = '0
) (
    input logic               clk,
    input logic               rst,
    elastic_operator_if.slave bus
);
    localparam int aw  = $clog2(fifo_depth);
    localparam int opc = op == "pass" ? 0 : op == "add" ? 1 : op == "sub" ? 2 : op == "mul" ? 3 :
                         op == "and" ? 4 : op == "or" ? 5 : op == "xor" ? 6 : op == "addi" ? 7 :
                         op == "subi" ? 8 : op == "muli" ? 9 : -1;

    if (opc < 0 || input_size < 1 || input_size > 8 || output_size < 1 || output_size > 8 ||
        fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0 ||
        ((opc == 0 || opc >= 7) && input_size != 1)) begin : g_bad_params
        $error("elastic_operator: unsupported op/parameter combination");
    end

    logic [data_width-1:0]  mem [input_size][fifo_depth];
    logic [aw-1:0]          wp [input_size];
    logic [aw-1:0]          rp [input_size];
    logic [aw:0]            cnt [input_size];
    logic [aw:0]            cnt_nx [input_size];
    logic [input_size-1:0]  nonempty, full, push, req_nx, ovf;
    logic [output_size-1:0] pending, ack_nx;
    logic                   fire;
    logic [data_width-1:0]  acc, x, res;

    always_comb begin
        nonempty = '0;
        full     = '0;
        push     = '0;
        req_nx   = '0;
        ovf      = '0;
        cnt_nx   = '{default: '0};
        for (int i = 0; i < input_size; i++) begin
            nonempty[i] = cnt[i] != '0;
            full[i]     = cnt[i] == (aw+1)'(fifo_depth);
        end
        fire = (&nonempty) && pending == '0;
        // a full FIFO still accepts a word in the same cycle it is popped
        for (int i = 0; i < input_size; i++) begin
            push[i]   = bus.ack_l[i] && (!full[i] || fire);
            ovf[i]    = bus.ack_l[i] && full[i] && !fire;
            cnt_nx[i] = cnt[i] + (aw+1)'(push[i]) - (aw+1)'(fire);
            req_nx[i] = cnt_nx[i] <= (aw+1)'(fifo_depth - 2);
        end
        ack_nx = bus.req_r & pending & ~bus.ack_r;
    end

    always_comb begin
        acc = mem[0][rp[0]];
        x   = '0;
        for (int i = 1; i < input_size; i++) begin
            x   = mem[i][rp[i]];
            acc = opc == 2 ? acc - x : opc == 3 ? acc * x : opc == 4 ? acc & x :
                  opc == 5 ? acc | x : opc == 6 ? acc ^ x : acc + x;
        end
        res = opc == 7 ? acc + immediate : opc == 8 ? acc - immediate :
              opc == 9 ? acc * immediate : acc;
    end

    always_ff @(posedge clk)
        for (int i = 0; i < input_size; i++)
            if (push[i]) mem[i][wp[i]] <= bus.din[i*data_width +: data_width];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < input_size; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
            pending        <= '0;
            bus.req_l      <= '0;
            bus.ack_r      <= '0;
            bus.dout       <= '0;
            bus.overflow   <= 1'b0;
            bus.fire_count <= '0;
        end else begin
            for (int i = 0; i < input_size; i++) begin
                if (push[i]) wp[i] <= wp[i] + aw'(1);
                if (fire) rp[i] <= rp[i] + aw'(1);
                cnt[i] <= cnt_nx[i];
            end
            bus.req_l <= req_nx;
            bus.ack_r <= ack_nx;
            // a fire only happens with nothing pending, so it never races an ack
            pending <= fire ? '1 : pending & ~ack_nx;
            if (|ovf) bus.overflow <= 1'b1;
            if (fire) begin
                bus.dout       <= res;
                bus.fire_count <= bus.fire_count + 32'd1;
            end
        end
    end
endmodule

// File: doc/elastic_operator.md
Name: elastic_operator

Overview:
- Parametrised successor of the dataflow operator node: an N-input, M-output arithmetic node with a per-input FIFO and independent per-output (eager-fork) acknowledgement.
- The FIFOs let inputs run ahead of the operation, so upstream producers no longer stall on a slow sibling input or on downstream.
- It sits inside generated dataflow graphs in place of an operator node plus a chain of reg nodes, using the same req/ack pulse protocol on both sides.

Parameters:
- data_width, 32, width of every data word.
- input_size, 2, number of input channels N (1..8).
- output_size, 1, number of output channels M (1..8).
- fifo_depth, 4, entries per input FIFO; power of two, at least 2.
- op, "add", one of "pass", "add", "sub", "mul", "and", "or", "xor", "addi", "subi", "muli".
- immediate, 0, constant operand for the *i ops.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low: state clears on a rising clk edge when rst==0.
- req_l  out  input_size  request to upstream channel i.
- ack_l  in  input_size  one-cycle pulse from upstream i; din slice i is valid in that cycle.
- din  in  data_width*input_size  input data; channel i occupies bits [data_width*(i+1)-1 : data_width*i].
- req_r  in  output_size  request from downstream channel j.
- ack_r  out  output_size  one-cycle ack pulse to downstream j.
- dout  out  data_width  result register, shared by all outputs.
- overflow  out  1  sticky error flag.
- fire_count  out  32  number of results produced since reset.

Behaviour:
- Reset (rst==0 at an edge): req_l=0, ack_r=0, dout=0, overflow=0, fire_count=0, all FIFOs empty, pending=0. Reset applied mid-transfer discards all buffered data and pending results.
- Input side, per channel i:
  - Push din[i] into FIFO i at every edge where ack_l[i]==1.
  - req_l[i] is a register: next value = (occupancy after this edge's push/pop) <= fifo_depth-2. This guarantees that an ack arriving one cycle after req falls always fits.
  - An ack_l[i] while FIFO i is full sets overflow=1 (sticky until reset) and drops the word; occupancy is unchanged.
  - A simultaneous push and pop is allowed at any occupancy, including full.
- Fire:
  - Fires at an edge where every FIFO is non-empty and pending==0 (the registered value).
  - On fire: pop one word from every FIFO, register the result into dout, set pending to all ones, and increment fire_count (wraps at 2^32).
- Output side, per channel j:
  - At an edge where req_r[j] & pending[j] & ~ack_r[j], set ack_r[j]=1 and clear pending[j]. Otherwise ack_r[j]=0 next cycle.
  - Each output is acknowledged independently. A slow output only holds the next fire; it never blocks the other outputs' acks.
  - dout is stable throughout every ack_r pulse: a new fire can occur at the edge where the last ack_r falls, and never earlier.
- Latency and throughput:
  - Data pushed at edge t fires at t+1 at the earliest, and ack_r rises at t+2 at the earliest.
  - Sustained throughput with req_r held high is one result per 2 cycles.
- Arithmetic (x0 = channel 0; all results truncated to data_width, unsigned wrap):
  - pass: x0 (input_size must be 1).
  - add, mul, and, or, xor: reduction over all N inputs.
  - sub: x0 minus the sum of the remaining inputs.
  - addi, subi, muli: x0 combined with immediate (input_size must be 1).
  - An unsupported op/input_size combination is an elaboration error.

Test Plan:
- Basic add, N=2, M=1, depth 4: din0=5, din1=7, consumer req held high -> ack_r pulses once with dout=12, fire_count=1, then ack_r=0 and req_l returns to 1.
- Skewed inputs: push 4 words on channel 0 (values 0..3) before any word on channel 1 -> req_l[0] drops once occupancy reaches 3. Then feed channel 1 with 10,10,10,10 -> outputs 10,11,12,13 in order, overflow stays 0.
- Eager fork, M=2: req_r[0] high, req_r[1] held low 6 cycles after the first fire -> ack_r[0] pulses exactly once. The second fire waits until ack_r[1] pulses, and both outputs see the same dout.
- Overflow: depth 2, drive ack_l[0] on 3 consecutive cycles while req_l[0]=0 and no fire -> overflow=1 and stays 1. The FIFO holds only the first 2 words.
- Wrap and ops: op="subi", immediate=3, input 1 -> dout=32'hFFFFFFFE. op="mul", N=3, inputs 2,3,4 -> dout=24.
- Reset mid-operation: pull rst low for one edge while 2 words are buffered and pending=1 -> all outputs are 0 next cycle, and the first result after reset uses only data pushed after reset.
